// File: rtl/mem_stage.sv
// mem_stage: LoongArch memory-access stage (EX -> MS -> WS), aligns/extends load data.
// Optional MS_LOAD_BUF_EN: buffers the load response so it survives WS back-pressure.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 175,
  parameter int MS_TO_WS_BUS_WD = 168
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic [39:0]                ms_forward,
  input  logic                       excp_flush,
  input  logic                       ertn_flush
);

  localparam logic [1:0] DROP_MAX = 2'd3;

  logic                       ms_valid_q, ms_valid_d;
  logic [ES_TO_MS_BUS_WD-1:0] es_bus_q;
  logic [1:0]                 drop_cnt_q, drop_cnt_d;

  logic        flush;
  logic        es_load;
  logic        ms_ready_go;
  logic        drop_busy;
  logic        resp_take;
  logic        drop_inc;
  logic        drop_dec;
  logic        resp_got;
  logic [31:0] load_word;
  logic [31:0] load_data;
  logic [31:0] final_result;
  logic        ms_ld_pending;

  // Decoded fields of the held instruction.
  logic        mem_wait;
  logic        mem_ld;
  logic [2:0]  ld_op;
  logic [1:0]  addr_lo;
  logic [31:0] pc;
  logic        ertn;
  logic [4:0]  dest;
  logic        gr_we;
  logic        res_from_csr;
  logic [31:0] alu_result;
  logic [95:0] csr_excp_tail;

  assign mem_wait      = es_bus_q[174];
  assign mem_ld        = es_bus_q[173];
  assign ld_op         = es_bus_q[172:170];
  assign addr_lo       = es_bus_q[169:168];
  assign pc            = es_bus_q[167:136];
  assign ertn          = es_bus_q[135];
  assign dest          = es_bus_q[134:130];
  assign gr_we         = es_bus_q[129];
  assign res_from_csr  = es_bus_q[128];
  assign alu_result    = es_bus_q[127:96];
  assign csr_excp_tail = es_bus_q[95:0];

  assign flush     = excp_flush | ertn_flush;
  assign drop_busy = (drop_cnt_q != 2'd0);

  // A response belongs to the current instruction only once all stale ones are gone.
  assign resp_take = data_sram_data_ok && !drop_busy && ms_valid_q && mem_wait && !resp_got;

`ifdef MS_LOAD_BUF_EN
  logic        resp_got_q, resp_got_d;
  logic [31:0] load_buf_q;

  assign resp_got    = resp_got_q;
  assign ms_ready_go = !mem_wait || resp_got_q;
  assign load_word   = load_buf_q;

  always_comb begin
    resp_got_d = resp_got_q;
    if (es_load) begin
      resp_got_d = 1'b0;
    end else if (resp_take) begin
      resp_got_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_got_q <= 1'b0;
    end else begin
      resp_got_q <= resp_got_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resp_take) begin
      load_buf_q <= data_sram_rdata;
    end
  end
`else
  assign resp_got    = 1'b0;
  assign ms_ready_go = !mem_wait || (data_sram_data_ok && !drop_busy);
  assign load_word   = data_sram_rdata;
`endif

  assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go && !flush;
  assign es_load        = es_to_ms_valid && ms_allowin;
  assign ms_ld_pending  = ms_valid_q && mem_ld && !ms_ready_go;

  always_comb begin
    ms_valid_d = ms_valid_q;
    if (flush) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end
  end

  // A flushed instruction still waiting on its response leaves one stale data_ok behind.
  assign drop_inc = flush && ms_valid_q && mem_wait && !resp_got && !resp_take;
  assign drop_dec = data_sram_data_ok && drop_busy;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_inc && !drop_dec && (drop_cnt_q != DROP_MAX)) begin
      drop_cnt_d = drop_cnt_q + 2'd1;
    end else if (drop_dec && !drop_inc) begin
      drop_cnt_d = drop_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q <= 1'b0;
      drop_cnt_q <= 2'd0;
    end else begin
      ms_valid_q <= ms_valid_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (es_load) begin
      es_bus_q <= es_to_ms_bus;
    end
  end

  // Lane candidates for byte and halfword loads.
  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
    assign byte_lane[gi] = load_word[8*gi +: 8];
  end
  for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
    assign half_lane[gi] = load_word[16*gi +: 16];
  end

  assign sel_byte = byte_lane[addr_lo];
  assign sel_half = half_lane[addr_lo[1]];

  always_comb begin
    load_data = load_word;
    case (ld_op)
      3'd0:    load_data = {{24{sel_byte[7]}}, sel_byte};
      3'd1:    load_data = {{16{sel_half[15]}}, sel_half};
      3'd3:    load_data = {24'd0, sel_byte};
      3'd4:    load_data = {16'd0, sel_half};
      default: load_data = load_word;
    endcase
  end

  assign final_result = mem_ld ? load_data : alu_result;

  assign ms_to_ws_bus = {pc, ertn, dest, gr_we, res_from_csr, final_result, csr_excp_tail};
  assign ms_forward   = {ms_valid_q, gr_we, dest, final_result, ms_ld_pending};

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the LoongArch core, between the execute stage and write-back. It accepts an instruction from EX, waits for the data-SRAM response of a load or store already issued by EX, and aligns and sign/zero-extends load data. It then drives the MS→WS bus consumed by write-back. It also forwards its result to decode and drops stale SRAM responses after a pipeline flush.

## Interface
Parameters
- ES_TO_MS_BUS_WD, 175: EX→MS bus width.
- MS_TO_WS_BUS_WD, 168: MS→WS bus width.

Ports (clock/reset: one clock; reset is synchronous and active-high)
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- ws_allowin  in  1  WS can accept
- ms_allowin  out  1  MS can accept from EX
- es_to_ms_valid  in  1  EX offers an instruction
- es_to_ms_bus  in  175  {mem_wait[1], mem_ld[1], ld_op[3], addr_lo[2], pc[32], ertn[1], dest[5], gr_we[1], res_from_csr[1], alu_result[32], excp[1], excp_num[16], csr_we[1], csr_num[14], csr_wmask[32], csr_wdata[32]}, MSB first
- ms_to_ws_valid  out  1  MS offers to WS
- ms_to_ws_bus  out  168  {pc, ertn, dest, gr_we, res_from_csr, final_result, excp, excp_num, csr_we, csr_num, csr_wmask, csr_wdata}, MSB first
- data_sram_data_ok  in  1  one response per issued request, in order
- data_sram_rdata  in  32  response data
- ms_forward  out  40  {ms_valid, gr_we, dest, final_result, ms_ld_pending}
- excp_flush  in  1  WS exception flush
- ertn_flush  in  1  WS ertn flush

## Operation
- ld_op encoding: 0 ld.b, 1 ld.h, 2 ld.w, 3 ld.bu, 4 ld.hu; 5–7 behave as ld.w.
- Load data selection: byte = rdata[8*addr_lo+7 : 8*addr_lo]; half = rdata[16*addr_lo[1]+15 : 16*addr_lo[1]]. .b/.h sign-extend; .bu/.hu zero-extend.
- final_result = mem_ld ? aligned load data : alu_result. All other fields pass through unchanged.
- mem_wait=1 means EX issued a request for this instruction (load or store). MS must see exactly one data_ok for it.
- ms_ready_go = !mem_wait || resp_got. ms_allowin = !ms_valid || (ms_ready_go && ws_allowin). ms_to_ws_valid = ms_valid && ms_ready_go && !flush.
- Input register loads on es_to_ms_valid && ms_allowin. resp_got clears on the same load.
- ms_ld_pending = ms_valid && mem_ld && !ms_ready_go. Decode stalls on it.
- Flush (excp_flush | ertn_flush):
  - ms_valid ← 0 next cycle.
  - If ms_valid && mem_wait && !resp_got at flush, and data_ok is not high that same cycle, drop_cnt increments.
- Stale responses: while drop_cnt ≠ 0, data_ok is consumed and decrements drop_cnt. It is not delivered to the current instruction.
- drop_cnt is 2 bits and saturates at 3. Increment and decrement in the same cycle leave it unchanged.

## Timing
- Reset: ms_valid=0, resp_got=0, drop_cnt=0. Consequently ms_to_ws_valid=0, ms_allowin=1, ms_forward[39]=0, ms_ld_pending=0. The bus register content is don't-care.
- Non-memory instruction: one cycle in MS.
- Memory instruction: leaves the cycle data_ok is accepted (no buffer) or the cycle after (buffer).
- A flush has priority over a simultaneous es_to_ms handshake. The incoming instruction is discarded and ms_valid=0 next cycle.
- Reset mid-wait clears drop_cnt. The SRAM side is reset concurrently.

## Configuration
- MS_LOAD_BUF_EN defined:
  - A data_ok accepted for the current instruction latches rdata into a 32-bit buffer and sets resp_got.
  - final_result uses the buffer, so the response survives ws_allowin=0.
  - Adds one cycle of load latency.
- Undefined:
  - No buffer. resp_got is never set.
  - ms_ready_go = !mem_wait || (data_ok && drop_cnt==0), and rdata is used combinationally.
  - ws_allowin must be 1 whenever data_ok is delivered.

## Test plan
- ALU op (mem_wait=0, alu_result=0x1234_5678, gr_we=1, dest=5): ms_to_ws_valid next cycle; final_result=0x1234_5678; ms_forward={1,1,5,0x12345678,0}.
- ld.b with addr_lo=2, rdata=0x0080_FF00, data_ok 3 cycles after entry: ms_ld_pending=1 for 3 cycles; final_result=0xFFFF_FF80. Repeat with ld.hu, addr_lo=2: final_result=0x0000_0080.
- Store (mem_wait=1, mem_ld=0, alu_result=0x100): held until data_ok; final_result=0x100.
- Load waiting, excp_flush pulse, then a new ld.w enters: the first data_ok (rdata=0xDEAD) is dropped; the second data_ok (rdata=0xBEEF) gives final_result=0x0000_BEEF.
- Flush coincident with data_ok and es_to_ms_valid: drop_cnt stays 0; the incoming instruction is discarded; ms_to_ws_valid=0 next cycle.
- With MS_LOAD_BUF_EN, ws_allowin=0 during data_ok (rdata=0xCAFE_F00D, ld.w): the instruction is held, and when ws_allowin rises final_result=0xCAFE_F00D.
